// File: rtl/rst_sequencer_pkg.sv
// Purpose: shared types for the staged reset sequencer (FSM states, reset causes, helpers).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rst_sequencer_pkg;

  // Sequencer states. The encoding 2'd3 is unused and recovers to ST_ASSERT.
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Cause of the most recent reset, as reported on rst_cause_o.
  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_WDT = 2'd2
  } cause_e;

  // Larger of two parameter values, used to size the shared sequence counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_wdt.sv
// Purpose: watchdog counter that flags a missed service window while the system runs.
// Latency: timeout_o is high in the cycle the count sits at TIMEOUT-1 with no kick/clear.
// Backpressure: none; enable, kick and clear are sampled every edge.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset, clears the count
//   en_i       count enable
//   kick_i     service pulse, clears the count and suppresses a pending timeout
//   clr_i      clear request from the sequencer (not running, or a reset is starting)
//   timeout_o  one-cycle pulse when the count expires
module rst_sequencer_wdt #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic kick_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam int unsigned    CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A kick, a clear or a disabled watchdog in the expiry cycle all mask the
  // pulse, so the kick-beats-timeout rule falls out of this one expression.
  assign timeout_o = en_i && !kick_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || kick_i || !en_i || timeout_o) begin
      // Clearing on the expiry cycle itself keeps the pulse to a single cycle
      // and leaves the count at zero when the sequencer leaves RUN.
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Purpose: staged reset sequencer with software and watchdog reset sources.
// Latency: all outputs are registered; an input change is visible after one edge.
// Backpressure: none; requests are sampled every edge, software requests during ASSERT are dropped.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset (power-on), overrides every other input
//   sw_rst_req_i  software reset request, acted on in RELEASE and RUN
//   wdt_en_i      watchdog enable
//   wdt_kick_i    watchdog service pulse
//   rst_stage_o   per-stage active-high reset, bit 0 released first
//   rst_done_o    all stages released
//   rst_cause_o   cause of the last reset: 0=POR, 1=SW, 2=WDT
//   busy_o        sequence in progress (inverse of rst_done_o)
module rst_sequencer #(
  parameter int unsigned N_STAGES      = 4,
  parameter int unsigned ASSERT_CYCLES = 8,
  parameter int unsigned STAGE_DLY     = 16,
  parameter int unsigned WDT_TIMEOUT   = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_rst_req_i,
  input  logic                wdt_en_i,
  input  logic                wdt_kick_i,
  output logic [N_STAGES-1:0] rst_stage_o,
  output logic                rst_done_o,
  output logic [1:0]          rst_cause_o,
  output logic                busy_o
);

  import rst_sequencer_pkg::*;

  // One counter serves both the hold time in ASSERT and the inter-stage gap
  // in RELEASE, so it is sized for the larger of the two.
  localparam int unsigned          CNT_MAX     = max_u(ASSERT_CYCLES, STAGE_DLY);
  localparam int unsigned          CNT_W       = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0]     ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     STAGE_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [N_STAGES-1:0]  ALL_ON      = {N_STAGES{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_STAGES-1:0]  stage_q, stage_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  cause_e               cause_q, cause_d;

  logic [CNT_W-1:0]     cnt_inc;
  logic [N_STAGES-1:0]  stage_next;
  logic                 wdt_clr;
  logic                 wdt_timeout;

  // The watchdog only runs in RUN. A software request also clears it so that
  // a simultaneous timeout is masked and the software cause is reported.
  assign wdt_clr = (state_q != ST_RUN) || sw_rst_req_i;

  rst_sequencer_wdt #(
    .TIMEOUT (WDT_TIMEOUT)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (wdt_en_i),
    .kick_i    (wdt_kick_i),
    .clr_i     (wdt_clr),
    .timeout_o (wdt_timeout)
  );

  // Saturating increment: the counter is always cleared before it could
  // reach its ceiling, but it must never wrap if that assumption breaks.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Stages release low bit first: shifting a zero in from the bottom turns
  // 1111 -> 1110 -> 1100 -> 1000 -> 0000, and a released bit can never
  // come back except through the all-ones load on entry to ASSERT.
  assign stage_next = stage_q << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = done_q;
    cause_d = cause_q;

    case (state_q)
      ST_ASSERT: begin
        // Software requests are deliberately ignored here: the hold time
        // already in progress is not restarted.
        if (cnt_q == ASSERT_LAST) begin
          cnt_d   = '0;
          stage_d = stage_next;
          if (stage_next == '0) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RELEASE: begin
        if (sw_rst_req_i) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          stage_d = ALL_ON;
          cause_d = CAUSE_SW;
        end else if (cnt_q == STAGE_LAST) begin
          cnt_d   = '0;
          stage_d = stage_next;
          if (stage_next == '0) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RUN: begin
        // Software takes priority; wdt_timeout is already masked by wdt_clr
        // in that case, the ordering here just makes the intent explicit.
        if (sw_rst_req_i || wdt_timeout) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          stage_d = ALL_ON;
          done_d  = 1'b0;
          cause_d = sw_rst_req_i ? CAUSE_SW : CAUSE_WDT;
        end
      end

      default: begin
        // Unused encoding: restart the sequence from a safe point.
        state_d = ST_ASSERT;
        cnt_d   = '0;
        stage_d = ALL_ON;
        done_d  = 1'b0;
      end
    endcase

    busy_d = ~done_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      stage_q <= ALL_ON;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign rst_stage_o = stage_q;
  assign rst_done_o  = done_q;
  assign busy_o      = busy_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Purpose: directed self-checking bench for rst_sequencer with default parameters.
// Latency: observes outputs 2 time units after each rising edge.
// Backpressure: n/a.
module tb_rst_sequencer;

  logic       clk_i;
  logic       rst_i;
  logic       sw_rst_req_i;
  logic       wdt_en_i;
  logic       wdt_kick_i;
  logic [3:0] rst_stage_o;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;
  logic       busy_o;

  int n_checks;
  int n_fail;
  int cyc;   // index of the last rising edge seen, relative to the current origin
  int kb;

  rst_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sw_rst_req_i (sw_rst_req_i),
    .wdt_en_i     (wdt_en_i),
    .wdt_kick_i   (wdt_kick_i),
    .rst_stage_o  (rst_stage_o),
    .rst_done_o   (rst_done_o),
    .rst_cause_o  (rst_cause_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
    cyc = cyc + n;
  endtask

  task automatic go_to(input int c);
    if (c > cyc) tick(c - cyc);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] stage, input logic done,
                           input logic busy, input logic [1:0] cause);
    check({tag, "/stage"}, 32'(rst_stage_o), 32'(stage));
    check({tag, "/done"},  32'(rst_done_o),  32'(done));
    check({tag, "/busy"},  32'(busy_o),      32'(busy));
    check({tag, "/cause"}, 32'(rst_cause_o), 32'(cause));
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    rst_i        = 1'b1;
    sw_rst_req_i = 1'b0;
    wdt_en_i     = 1'b0;
    wdt_kick_i   = 1'b0;

    // Power-on reset: two edges with rst_i high. The last of them is edge 0.
    tick(2);
    check_all("por_reset", 4'hF, 1'b0, 1'b1, 2'd0);
    cyc   = 0;
    rst_i = 1'b0;

    // Software request during ASSERT must not restart the hold time.
    go_to(3);  sw_rst_req_i = 1'b1;
    go_to(4);  sw_rst_req_i = 1'b0;
    check("assert_sw_ignored", 32'(rst_stage_o), 32'hF);
    go_to(7);  check("por_pre_bit0", 32'(rst_stage_o), 32'hF);
    go_to(8);  check_all("por_bit0", 4'hE, 1'b0, 1'b1, 2'd0);
    go_to(23); check("por_pre_bit1", 32'(rst_stage_o), 32'hE);
    go_to(24); check("por_bit1", 32'(rst_stage_o), 32'hC);
    go_to(40); check("por_bit2", 32'(rst_stage_o), 32'h8);
    go_to(55); check_all("por_pre_done", 4'h8, 1'b0, 1'b1, 2'd0);
    go_to(56); check_all("por_done", 4'h0, 1'b1, 1'b0, 2'd0);

    // Software reset from RUN.
    go_to(100); sw_rst_req_i = 1'b1;
    go_to(101); sw_rst_req_i = 1'b0;
    check_all("sw_run_entry", 4'hF, 1'b0, 1'b1, 2'd1);
    go_to(108); check("sw_pre_bit0", 32'(rst_stage_o), 32'hF);
    go_to(109); check("sw_bit0", 32'(rst_stage_o), 32'hE);
    go_to(156); check("sw_pre_done", 32'(rst_done_o), 32'd0);
    go_to(157); check_all("sw_done", 4'h0, 1'b1, 1'b0, 2'd1);

    // Fresh power-on, then a software restart in RELEASE at cycle 30.
    rst_i = 1'b1;
    tick(2);
    check_all("por2_reset", 4'hF, 1'b0, 1'b1, 2'd0);
    cyc   = 0;
    rst_i = 1'b0;
    go_to(30); check("rel_pre_restart", 32'(rst_stage_o), 32'hC);
    sw_rst_req_i = 1'b1;
    go_to(31); sw_rst_req_i = 1'b0;
    check_all("rel_restart", 4'hF, 1'b0, 1'b1, 2'd1);
    go_to(38); check("rel_pre_bit0", 32'(rst_stage_o), 32'hF);
    go_to(39); check("rel_bit0", 32'(rst_stage_o), 32'hE);
    go_to(55); check("rel_bit1", 32'(rst_stage_o), 32'hC);

    // rst_i mid-RELEASE, 30 cycles into the restarted sequence.
    go_to(61); check("rst_mid_pre", 32'(rst_stage_o), 32'hC);
    rst_i = 1'b1;
    go_to(62); check_all("rst_mid", 4'hF, 1'b0, 1'b1, 2'd0);
    rst_i = 1'b0;
    go_to(69);  check("rst_mid_pre_bit0", 32'(rst_stage_o), 32'hF);
    go_to(70);  check("rst_mid_bit0", 32'(rst_stage_o), 32'hE);
    go_to(117); check("rst_mid_pre_done", 32'(rst_done_o), 32'd0);
    go_to(118); check_all("rst_mid_done", 4'h0, 1'b1, 1'b0, 2'd0);

    // Watchdog with no kicks: RUN entered at edge 118, timeout reset at 1142.
    wdt_en_i = 1'b1;
    go_to(1141); check_all("wdt_pre_timeout", 4'h0, 1'b1, 1'b0, 2'd0);
    go_to(1142); check_all("wdt_timeout", 4'hF, 1'b0, 1'b1, 2'd2);
    go_to(1198); check_all("wdt_seq_done", 4'h0, 1'b1, 1'b0, 2'd2);

    // Kicking every 500 cycles keeps the system running for 5000 cycles.
    for (int i = 0; i < 10; i++) begin
      go_to(cyc + 499);
      wdt_kick_i = 1'b1;
      tick(1);
      wdt_kick_i = 1'b0;
      check($sformatf("kick_%0d_done", i), 32'(rst_done_o), 32'd1);
    end
    check("kick_cause_held", 32'(rst_cause_o), 32'd2);

    // Kick in the exact timeout cycle: the kick wins.
    kb = cyc;
    go_to(kb + 1023); check("kick_race_pre", 32'(rst_done_o), 32'd1);
    wdt_kick_i = 1'b1;
    tick(1);
    wdt_kick_i = 1'b0;
    check_all("kick_race", 4'h0, 1'b1, 1'b0, 2'd2);

    // Software request in the exact timeout cycle: software wins.
    go_to(kb + 1024 + 1022); check("sw_race_pre", 32'(rst_done_o), 32'd1);
    go_to(kb + 1024 + 1023);
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    check_all("sw_race", 4'hF, 1'b0, 1'b1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
